// File: rtl/tx_buffer_memory_if.sv
// tx_buffer_memory_if: PL fill/commit and MAC read/release signals of the TX frame buffer
interface tx_buffer_memory_if #(parameter int data_width_p = 64);
  logic                    write_slot_v;
  logic                    write_v;
  logic [10:0]             write_addr;
  logic [data_width_p-1:0] write_data;
  logic [1:0]              write_op_size;
  logic                    send_v;
  logic [15:0]             send_size;
  logic                    read_slot_v;
  logic [15:0]             read_size_r;
  logic                    read_slot_yumi;
  logic                    read_v;
  logic [10:0]             read_addr;
  logic [data_width_p-1:0] read_data;
  modport slave (
    output write_slot_v, read_slot_v, read_size_r, read_data,
    input  write_v, write_addr, write_data, write_op_size, send_v, send_size,
           read_slot_yumi, read_v, read_addr
  );
  modport master (
    input  write_slot_v, read_slot_v, read_size_r, read_data,
    output write_v, write_addr, write_data, write_op_size, send_v, send_size,
           read_slot_yumi, read_v, read_addr
  );
endinterface

// File: rtl/tx_buffer_memory.sv
// tx_buffer_memory: slot-based TX frame FIFO, PL fills/commits frames, MAC reads/releases them in order
module tx_buffer_memory #(
  parameter int slot_p       = 2,
  parameter int data_width_p = 64
) (
  input logic clk_i,
  input logic reset_n_i,
  tx_buffer_memory_if.slave bus
);
  localparam int els_lp        = 2048;
  localparam int addr_width_lp = $clog2(els_lp);
  localparam int size_width_lp = 16;
  localparam int bytes_lp      = data_width_p / 8;
  localparam int lsb_lp        = $clog2(bytes_lp);
  localparam int words_lp      = els_lp / bytes_lp;
  localparam int ptr_w_lp      = (slot_p > 1) ? $clog2(slot_p) : 1;
  logic [ptr_w_lp-1:0] wptr_r, rptr_r, rd_slot_r, wptr_n, rptr_n;
  logic full_r, empty_r;
  logic [size_width_lp-1:0] size_r [slot_p];
  logic enq, deq, wr_en, rd_en;
  logic [lsb_lp-1:0] lane;
  logic [data_width_p-1:0] wdata;
  logic [15:0] mask_full;
  logic [bytes_lp-1:0] wmask;
  logic [addr_width_lp-lsb_lp-1:0] waddr, raddr;
  logic [slot_p-1:0][data_width_p-1:0] q_all;
  assign bus.write_slot_v = ~full_r;
  assign bus.read_slot_v  = ~empty_r;
  assign enq   = bus.send_v & ~full_r;
  assign deq   = bus.read_slot_yumi & ~empty_r;
  assign wr_en = bus.write_v & ~full_r;
  assign rd_en = bus.read_v & ~empty_r;
  assign wptr_n = (wptr_r == ptr_w_lp'(slot_p - 1)) ? '0 : wptr_r + 1'b1;
  assign rptr_n = (rptr_r == ptr_w_lp'(slot_p - 1)) ? '0 : rptr_r + 1'b1;
  // Right-aligned write data is moved onto its byte lanes; mask spans 1<<op bytes
  assign lane      = bus.write_addr[lsb_lp-1:0];
  assign wdata     = bus.write_data << {lane, 3'b000};
  assign mask_full = ((16'd1 << (4'd1 << bus.write_op_size)) - 16'd1) << lane;
  assign wmask     = mask_full[bytes_lp-1:0];
  assign waddr     = bus.write_addr[addr_width_lp-1:lsb_lp];
  assign raddr     = bus.read_addr[addr_width_lp-1:lsb_lp];
  assign bus.read_size_r = size_r[rptr_r];
  assign bus.read_data   = q_all[rd_slot_r];
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      rd_slot_r <= '0;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      for (int i = 0; i < slot_p; i++) size_r[i] <= '0;
    end else begin
      if (enq) begin
        size_r[wptr_r] <= bus.send_size;
        wptr_r         <= wptr_n;
      end
      if (deq) rptr_r <= rptr_n;
      // Remember which slot was read so a same-cycle release cannot redirect the data
      if (rd_en) rd_slot_r <= rptr_r;
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= (wptr_n == rptr_r);
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= (rptr_n == wptr_r);
      end
    end
  for (genvar s = 0; s < slot_p; s++) begin : g_slot
    logic [data_width_p-1:0] mem [words_lp];
    logic [data_width_p-1:0] q;
    always_ff @(posedge clk_i) begin
      if (wr_en && wptr_r == ptr_w_lp'(s))
        for (int b = 0; b < bytes_lp; b++)
          if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      if (rd_en && rptr_r == ptr_w_lp'(s)) q <= mem[raddr];
    end
    assign q_all[s] = q;
  end
`ifndef SYNTHESIS
  always @(posedge clk_i)
    if (reset_n_i) begin
      assert (data_width_p == 32 || data_width_p == 64)
        else $error("data_width_p must be 32 or 64");
      assert (!(bus.write_v && (bus.write_addr & ((11'd1 << bus.write_op_size) - 11'd1)) != 11'd0))
        else $error("misaligned write");
      assert (!(bus.write_v && data_width_p == 32 && bus.write_op_size == 2'd3))
        else $error("illegal write op size");
      assert (!(bus.read_v && bus.read_addr[lsb_lp-1:0] != '0))
        else $error("misaligned read");
      assert (!(bus.read_slot_yumi && empty_r))
        else $error("yumi with no frame");
    end
`endif
endmodule

// File: tb/tb_tx_buffer_memory.sv
// tb_tx_buffer_memory: directed checks of fill, commit, FIFO order, full/empty and reset of the TX buffer
module tb_tx_buffer_memory;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  tx_buffer_memory_if #(.data_width_p(64)) bus();
  tx_buffer_memory #(.slot_p(2), .data_width_p(64)) dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [10:0] a, input logic [63:0] d, input logic [1:0] op);
    bus.write_v = 1'b1; bus.write_addr = a; bus.write_data = d; bus.write_op_size = op;
    tick();
    bus.write_v = 1'b0;
  endtask
  task automatic send(input logic [15:0] sz);
    bus.send_v = 1'b1; bus.send_size = sz;
    tick();
    bus.send_v = 1'b0;
  endtask
  task automatic rd(input logic [10:0] a);
    bus.read_v = 1'b1; bus.read_addr = a;
    tick();
    bus.read_v = 1'b0;
  endtask
  task automatic yumi();
    bus.read_slot_yumi = 1'b1;
    tick();
    bus.read_slot_yumi = 1'b0;
  endtask
  task automatic test_reset();
    n_cmp++; if (bus.write_slot_v !== 1'b1) begin n_err++; $display("FAIL rst_wsv: got %b want 1", bus.write_slot_v); end
    n_cmp++; if (bus.read_slot_v !== 1'b0) begin n_err++; $display("FAIL rst_rsv: got %b want 0", bus.read_slot_v); end
    n_cmp++; if (bus.read_size_r !== 16'd0) begin n_err++; $display("FAIL rst_size: got %0d want 0", bus.read_size_r); end
  endtask
  task automatic test_byte_writes();
    for (int i = 0; i < 8; i++) wr(11'(i), 64'(8'h11 + i), 2'd0);
    send(16'd8);
    n_cmp++; if (bus.read_slot_v !== 1'b1) begin n_err++; $display("FAIL t1_rsv: got %b want 1", bus.read_slot_v); end
    n_cmp++; if (bus.read_size_r !== 16'd8) begin n_err++; $display("FAIL t1_size: got %0d want 8", bus.read_size_r); end
    rd(11'h0);
    n_cmp++; if (bus.read_data !== 64'h1817161514131211) begin n_err++; $display("FAIL t1_data: got %h want 1817161514131211", bus.read_data); end
    yumi();
    n_cmp++; if (bus.read_slot_v !== 1'b0) begin n_err++; $display("FAIL t1_empty: got %b want 0", bus.read_slot_v); end
  endtask
  task automatic test_mixed_sizes();
    wr(11'h0, 64'hAA, 2'd0);
    wr(11'h1, 64'h55, 2'd0);
    wr(11'h2, 64'hBEEF, 2'd1);
    wr(11'h4, 64'hCAFEF00D, 2'd2);
    send(16'd8);
    rd(11'h0);
    n_cmp++; if (bus.read_data !== 64'hCAFEF00DBEEF55AA) begin n_err++; $display("FAIL t2_data: got %h want cafef00dbeef55aa", bus.read_data); end
    yumi();
  endtask
  task automatic test_full();
    wr(11'h0, 64'h0123456789ABCDEF, 2'd3);
    send(16'd60);
    wr(11'h0, 64'h1122334455667788, 2'd3);
    send(16'd64);
    n_cmp++; if (bus.write_slot_v !== 1'b0) begin n_err++; $display("FAIL t3_full: got %b want 0", bus.write_slot_v); end
    wr(11'h0, 64'hFF, 2'd0);
    send(16'd99);
    n_cmp++; if (bus.read_size_r !== 16'd60) begin n_err++; $display("FAIL t3_size60: got %0d want 60", bus.read_size_r); end
    rd(11'h0);
    n_cmp++; if (bus.read_data !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL t3_frameA: got %h want 0123456789abcdef", bus.read_data); end
    bus.read_slot_yumi = 1'b1;
    #1;
    n_cmp++; if (bus.write_slot_v !== 1'b0) begin n_err++; $display("FAIL t3_nobypass: got %b want 0", bus.write_slot_v); end
    tick();
    bus.read_slot_yumi = 1'b0;
    n_cmp++; if (bus.write_slot_v !== 1'b1) begin n_err++; $display("FAIL t3_wsv: got %b want 1", bus.write_slot_v); end
    n_cmp++; if (bus.read_size_r !== 16'd64) begin n_err++; $display("FAIL t3_size64: got %0d want 64", bus.read_size_r); end
    rd(11'h0);
    n_cmp++; if (bus.read_data !== 64'h1122334455667788) begin n_err++; $display("FAIL t3_frameB: got %h want 1122334455667788", bus.read_data); end
    yumi();
  endtask
  task automatic test_enq_deq();
    wr(11'h8, 64'hC1C1C1C1C1C1C1C1, 2'd3);
    send(16'd60);
    bus.write_v = 1'b1; bus.write_addr = 11'h8; bus.write_data = 64'hD1D1D1D1D1D1D1D1; bus.write_op_size = 2'd3;
    bus.send_v = 1'b1; bus.send_size = 16'd100;
    bus.read_slot_yumi = 1'b1;
    tick();
    bus.write_v = 1'b0; bus.send_v = 1'b0; bus.read_slot_yumi = 1'b0;
    n_cmp++; if (bus.read_slot_v !== 1'b1) begin n_err++; $display("FAIL t4_rsv: got %b want 1", bus.read_slot_v); end
    n_cmp++; if (bus.read_size_r !== 16'd100) begin n_err++; $display("FAIL t4_size: got %0d want 100", bus.read_size_r); end
    n_cmp++; if (bus.write_slot_v !== 1'b1) begin n_err++; $display("FAIL t4_wsv: got %b want 1", bus.write_slot_v); end
  endtask
  task automatic test_back_to_back();
    wr(11'h8, 64'hE1E1E1E1E1E1E1E1, 2'd3);
    send(16'd120);
    bus.read_v = 1'b1; bus.read_addr = 11'h8; bus.read_slot_yumi = 1'b1;
    tick();
    bus.read_v = 1'b0; bus.read_slot_yumi = 1'b0;
    n_cmp++; if (bus.read_data !== 64'hD1D1D1D1D1D1D1D1) begin n_err++; $display("FAIL t5_old: got %h want d1d1d1d1d1d1d1d1", bus.read_data); end
    n_cmp++; if (bus.read_size_r !== 16'd120) begin n_err++; $display("FAIL t5_size: got %0d want 120", bus.read_size_r); end
    rd(11'h8);
    n_cmp++; if (bus.read_data !== 64'hE1E1E1E1E1E1E1E1) begin n_err++; $display("FAIL t5_new: got %h want e1e1e1e1e1e1e1e1", bus.read_data); end
    yumi();
    n_cmp++; if (bus.read_slot_v !== 1'b0) begin n_err++; $display("FAIL t5_empty: got %b want 0", bus.read_slot_v); end
  endtask
  task automatic test_reset_mid();
    wr(11'h0, 64'h3333333333333333, 2'd3);
    send(16'd30);
    wr(11'h0, 64'h4444444444444444, 2'd3);
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++; if (bus.read_slot_v !== 1'b0) begin n_err++; $display("FAIL t6_rsv: got %b want 0", bus.read_slot_v); end
    n_cmp++; if (bus.write_slot_v !== 1'b1) begin n_err++; $display("FAIL t6_wsv: got %b want 1", bus.write_slot_v); end
    n_cmp++; if (bus.read_size_r !== 16'd0) begin n_err++; $display("FAIL t6_size: got %0d want 0", bus.read_size_r); end
    #1 reset_n_i = 1'b1;
    tick();
    wr(11'h10, 64'h0F0E0D0C0B0A0908, 2'd3);
    wr(11'h1A, 64'h7766, 2'd1);
    send(16'd24);
    n_cmp++; if (bus.read_size_r !== 16'd24) begin n_err++; $display("FAIL t6_newsize: got %0d want 24", bus.read_size_r); end
    rd(11'h10);
    n_cmp++; if (bus.read_data !== 64'h0F0E0D0C0B0A0908) begin n_err++; $display("FAIL t6_w2: got %h want 0f0e0d0c0b0a0908", bus.read_data); end
    rd(11'h18);
    n_cmp++; if (bus.read_data[31:16] !== 16'h7766) begin n_err++; $display("FAIL t6_half: got %h want 7766", bus.read_data[31:16]); end
  endtask
  initial begin
    bus.write_v = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.write_op_size = '0;
    bus.send_v = 1'b0; bus.send_size = '0;
    bus.read_slot_yumi = 1'b0; bus.read_v = 1'b0; bus.read_addr = '0;
    repeat (2) tick();
    test_reset();
    reset_n_i = 1'b1;
    tick();
    test_reset();
    test_byte_writes();
    test_mixed_sizes();
    test_full();
    test_enq_deq();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
